// File: rtl/counter_mod_n.sv
// counter_mod_n: modulo-n up-counter with clock enable and carry-out.
// Counts enabled cycles 0..n-1. co marks the enabled cycle that wraps
// the count, so instances cascade and co doubles as a slow tick strobe.
module counter_mod_n #(
    parameter int n            = 10,
    parameter int counter_bits = 4
) (
    input  logic                    clk,
    input  logic                    r,
    input  logic                    en,
    output logic [counter_bits-1:0] q,
    output logic                    co
);

    // Reject moduli that are degenerate or that q cannot represent.
    if (n < 2 || longint'(n) > (longint'(1) << counter_bits)) begin : g_bad_param
        $error("counter_mod_n: n=%0d illegal for counter_bits=%0d", n, counter_bits);
    end

    localparam logic [counter_bits-1:0] LAST = counter_bits'(n - 1);

    logic [counter_bits-1:0] q_q;
    logic [counter_bits-1:0] q_d;

    // Next count. ">=" rather than "==" so a corrupted value above the
    // terminal count recovers to 0 on the next enabled edge.
    always_comb begin
        q_d = q_q + 1'b1;
        if (q_q >= LAST) begin
            q_d = '0;
        end
    end

    // Count register: reset wins over enable; hold when disabled.
    always_ff @(posedge clk) begin
        if (r) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= q_d;
        end
    end

    // Carry-out follows en combinationally while sitting at the terminal count.
    always_comb begin
        co = en & (q_q == LAST);
    end

    assign q = q_q;

endmodule

// File: tb/tb_counter_mod_n.sv
// Bench for counter_mod_n: a large instance (n=1000) and a small one (n=2)
// driven by the same r/en, each checked against a reference model through
// a scoreboard of expected q values.
module tb_counter_mod_n;

    localparam int N_BIG   = 1000;
    localparam int B_BIG   = 10;
    localparam int N_SMALL = 2;
    localparam int B_SMALL = 1;

    logic             clk;
    logic             r;
    logic             en;
    logic [B_BIG-1:0] q_big;
    logic             co_big;
    logic [B_SMALL-1:0] q_small;
    logic             co_small;

    int n_chk  = 0;
    int n_pass = 0;

    int m_big   = 0;
    int m_small = 0;
    bit m_valid = 0;
    int cyc_no  = 0;

    int sb_big[$];
    int sb_small[$];
    int co_cycs[$];

    counter_mod_n #(.n(N_BIG), .counter_bits(B_BIG)) u_big (
        .clk (clk),
        .r   (r),
        .en  (en),
        .q   (q_big),
        .co  (co_big)
    );

    counter_mod_n #(.n(N_SMALL), .counter_bits(B_SMALL)) u_small (
        .clk (clk),
        .r   (r),
        .en  (en),
        .q   (q_small),
        .co  (co_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc_no);
        end
    endtask

    function automatic int model_next(input int cur, input int modn, input logic rr, input logic ee);
        if (rr) return 0;
        if (!ee) return cur;
        return (cur >= modn - 1) ? 0 : cur + 1;
    endfunction

    // One clock: drive inputs, check co, push expected q, then check q after the edge.
    task automatic cyc(input logic r_v, input logic en_v);
        int exp_big;
        int exp_small;
        r  = r_v;
        en = en_v;
        #1;
        if (m_valid) begin
            chk("co_big", 32'(co_big), 32'(en_v && (m_big == N_BIG - 1)));
            chk("co_small", 32'(co_small), 32'(en_v && (m_small == N_SMALL - 1)));
        end
        if (co_big === 1'b1) co_cycs.push_back(cyc_no);
        m_big   = model_next(m_big, N_BIG, r_v, en_v);
        m_small = model_next(m_small, N_SMALL, r_v, en_v);
        if (r_v) m_valid = 1;
        sb_big.push_back(m_big);
        sb_small.push_back(m_small);
        @(posedge clk);
        #1;
        cyc_no++;
        exp_big   = sb_big.pop_front();
        exp_small = sb_small.pop_front();
        if (m_valid) begin
            chk("q_big", 32'(q_big), 32'(exp_big));
            chk("q_small", 32'(q_small), 32'(exp_small));
        end
    endtask

    task automatic run_to(input int target);
        int budget;
        budget = 2 * N_BIG;
        while (m_big != target && budget > 0) begin
            cyc(1'b0, 1'b1);
            budget--;
        end
        chk("run_to", 32'(m_big), 32'(target));
    endtask

    initial begin
        r  = 1'b0;
        en = 1'b0;
        @(posedge clk);
        #1;

        // Reset with en low, then hold at 0.
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);

        // Free run two full periods; co must recur every N_BIG clocks.
        co_cycs.delete();
        repeat (2 * N_BIG) cyc(1'b0, 1'b1);
        chk("co_count", 32'(co_cycs.size()), 32'd2);
        if (co_cycs.size() == 2) begin
            chk("co_period", 32'(co_cycs[1] - co_cycs[0]), 32'(N_BIG));
        end

        // Gated enable: one enabled edge every 11 clocks.
        repeat (120) begin
            repeat (10) cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b1);
        end
        chk("gated_q", 32'(q_big), 32'd120);

        // Hold at terminal count, then release.
        run_to(N_BIG - 1);
        repeat (5) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("wrap_after_hold", 32'(q_big), 32'd0);

        // Reset priority mid-count and at terminal count.
        run_to(500);
        cyc(1'b1, 1'b1);
        run_to(N_BIG - 1);
        cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b1);
        chk("post_reset_q", 32'(q_big), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
